sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arb_pkg.sv | 18 +
 rtl/sdram_arb_pick.sv | 31 +++
 rtl/sdram_arbiter.sv | 156 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared constants and types for the three-port SDRAM slot arbiter.
package sdram_arb_pkg;

    localparam int SLOT_LEN  = 8;
    localparam int NUM_PORTS = 3;

    // Position inside the 8-clock slot.
    typedef logic [2:0] cnt_t;

    // Fields a master presents with its request.
    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [1:0]  ds;
        logic [15:0] din;
    } port_req_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Masked fixed-priority selector: port 0 wins over 1, 1 over 2.
module sdram_arb_pick
    import sdram_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] mask_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic                 valid_o
);

    logic [NUM_PORTS-1:0] elig_s;
    logic                 found_s;

    assign elig_s  = req_i & ~mask_i;
    assign valid_o = |elig_s;

    // Lowest-numbered eligible port takes the grant.
    always_comb begin
        grant_o = {NUM_PORTS{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (elig_s[i] && !found_s) begin
                grant_o[i] = 1'b1;
                found_s    = 1'b1;
            end else begin
                grant_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Slot-based three-port SDRAM arbiter. Each 8-clock slot carries at most one
// access; an idle slot (oe=we=0) lets the controller auto-refresh.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int REFRESH_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [23:0] p0_addr,
    input  logic [1:0]  p0_ds,
    input  logic [15:0] p0_din,
    output logic        p0_ack,
    output logic [15:0] p0_dout,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [23:0] p1_addr,
    input  logic [1:0]  p1_ds,
    input  logic [15:0] p1_din,
    output logic        p1_ack,
    output logic [15:0] p1_dout,

    input  logic        p2_req,
    input  logic        p2_we,
    input  logic [23:0] p2_addr,
    input  logic [1:0]  p2_ds,
    input  logic [15:0] p2_din,
    output logic        p2_ack,
    output logic [15:0] p2_dout,

    output logic        sd_sync,
    output logic        sd_oe,
    output logic        sd_we,
    output logic [23:0] sd_addr,
    output logic [1:0]  sd_ds,
    output logic [15:0] sd_din,
    input  logic [15:0] sd_dout
);

    localparam int BUSY_W = $clog2(REFRESH_MAX + 1);

    cnt_t                 cnt_q, cnt_d;
    logic                 sync_q;
    logic                 oe_q, we_q;
    logic [23:0]          addr_q;
    logic [1:0]           ds_q;
    logic [15:0]          din_q;
    logic [NUM_PORTS-1:0] ack_q;
    logic [15:0]          dout_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] serving_q;
    logic [BUSY_W-1:0]    busy_q;

    logic [NUM_PORTS-1:0] req_vec_s;
    port_req_t            preq_s [NUM_PORTS];
    logic [NUM_PORTS-1:0] pick_grant_s;
    logic                 pick_valid_s;
    logic                 force_idle_s;
    logic [NUM_PORTS-1:0] grant_s;
    logic                 grant_valid_s;
    port_req_t            sel_s;
    logic                 slot_end_s;

    assign req_vec_s = {p2_req, p1_req, p0_req};
    assign preq_s[0] = '{we: p0_we, addr: p0_addr, ds: p0_ds, din: p0_din};
    assign preq_s[1] = '{we: p1_we, addr: p1_addr, ds: p1_ds, din: p1_din};
    assign preq_s[2] = '{we: p2_we, addr: p2_addr, ds: p2_ds, din: p2_din};

    assign cnt_d      = cnt_q + 3'd1;
    assign slot_end_s = (cnt_q == 3'd7);

    // The port being served now may not win the next slot.
    sdram_arb_pick u_pick (
        .req_i   (req_vec_s),
        .mask_i  (serving_q),
        .grant_o (pick_grant_s),
        .valid_o (pick_valid_s)
    );

    assign force_idle_s  = (busy_q == BUSY_W'(REFRESH_MAX));
    assign grant_s       = force_idle_s ? {NUM_PORTS{1'b0}} : pick_grant_s;
    assign grant_valid_s = pick_valid_s & ~force_idle_s;

    // Route the winning port's request fields.
    always_comb begin
        sel_s = preq_s[0];
        case (grant_s)
            3'b010:  sel_s = preq_s[1];
            3'b100:  sel_s = preq_s[2];
            default: sel_s = preq_s[0];
        endcase
    end

    // Slot timing, grant registration, ack/read-data return and refresh pacing.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= 3'd0;
            sync_q    <= 1'b0;
            oe_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 24'd0;
            ds_q      <= 2'd0;
            din_q     <= 16'd0;
            ack_q     <= {NUM_PORTS{1'b0}};
            serving_q <= {NUM_PORTS{1'b0}};
            busy_q    <= {BUSY_W{1'b0}};
            for (int i = 0; i < NUM_PORTS; i++) begin
                dout_q[i] <= 16'd0;
            end
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= ~cnt_d[2];
            ack_q  <= {NUM_PORTS{1'b0}};
            if (slot_end_s) begin
                // Close the slot that is ending.
                ack_q <= serving_q;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (serving_q[i] && oe_q) begin
                        dout_q[i] <= sd_dout;
                    end
                end
                // Open the next slot.
                serving_q <= grant_s;
                if (grant_valid_s) begin
                    oe_q   <= ~sel_s.we;
                    we_q   <= sel_s.we;
                    addr_q <= sel_s.addr;
                    ds_q   <= sel_s.ds;
                    din_q  <= sel_s.din;
                    busy_q <= busy_q + BUSY_W'(1);
                end else begin
                    oe_q   <= 1'b0;
                    we_q   <= 1'b0;
                    busy_q <= {BUSY_W{1'b0}};
                end
            end
        end
    end

    assign sd_sync = sync_q;
    assign sd_oe   = oe_q;
    assign sd_we   = we_q;
    assign sd_addr = addr_q;
    assign sd_ds   = ds_q;
    assign sd_din  = din_q;
    assign p0_ack  = ack_q[0];
    assign p1_ack  = ack_q[1];
    assign p2_ack  = ack_q[2];
    assign p0_dout = dout_q[0];
    assign p1_dout = dout_q[1];
    assign p2_dout = dout_q[2];

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: single read/write, priority rotation,
// forced refresh slots, masked write, idle slots and mid-slot reset.
module tb_sdram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we, p2_req, p2_we;
    logic [23:0] p0_addr, p1_addr, p2_addr;
    logic [1:0]  p0_ds, p1_ds, p2_ds;
    logic [15:0] p0_din, p1_din, p2_din;
    logic        p0_ack, p1_ack, p2_ack;
    logic [15:0] p0_dout, p1_dout, p2_dout;
    logic        sd_sync, sd_oe, sd_we;
    logic [23:0] sd_addr;
    logic [1:0]  sd_ds;
    logic [15:0] sd_din, sd_dout;

    int n_cmp = 0;
    int n_bad = 0;
    int tb_cnt = 0;

    sdram_arbiter #(.REFRESH_MAX(16)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_ds(p0_ds),
        .p0_din(p0_din), .p0_ack(p0_ack), .p0_dout(p0_dout),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_ds(p1_ds),
        .p1_din(p1_din), .p1_ack(p1_ack), .p1_dout(p1_dout),
        .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_ds(p2_ds),
        .p2_din(p2_din), .p2_ack(p2_ack), .p2_dout(p2_dout),
        .sd_sync(sd_sync), .sd_oe(sd_oe), .sd_we(sd_we), .sd_addr(sd_addr),
        .sd_ds(sd_ds), .sd_din(sd_din), .sd_dout(sd_dout)
    );

    // Bench-side slot position: restarts at 0 on reset, wraps every 8 clk.
    always @(posedge clk) begin
        if (reset) tb_cnt <= 0;
        else       tb_cnt <= (tb_cnt + 1) % 8;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the first clock of the next slot (bounded).
    task automatic to_slot_start();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tb_cnt != 0 && n < 16);
        if (tb_cnt != 0) check("slot_bound", tb_cnt, 0);
    endtask

    // Check sd_* held for all 8 clocks of the slot; no ack inside the slot.
    // Entered at cnt 0, leaves at cnt 7.
    task automatic check_slot(input string tag, input logic oe, input logic we,
                              input logic [23:0] addr, input logic [1:0] ds,
                              input logic [15:0] din);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(negedge clk);
                check({tag, "_noack"}, {p2_ack, p1_ack, p0_ack}, 3'b000);
            end
            check({tag, "_oe"},   sd_oe,   oe);
            check({tag, "_we"},   sd_we,   we);
            check({tag, "_addr"}, sd_addr, addr);
            check({tag, "_ds"},   sd_ds,   ds);
            check({tag, "_din"},  sd_din,  din);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sync"}, sd_sync, 1'b0);
        check({tag, "_oe"},   sd_oe,   1'b0);
        check({tag, "_we"},   sd_we,   1'b0);
        check({tag, "_addr"}, sd_addr, 24'd0);
        check({tag, "_ds"},   sd_ds,   2'd0);
        check({tag, "_din"},  sd_din,  16'd0);
        check({tag, "_ack"},  {p2_ack, p1_ack, p0_ack}, 3'b000);
        check({tag, "_d0"},   p0_dout, 16'd0);
        check({tag, "_d1"},   p1_dout, 16'd0);
        check({tag, "_d2"},   p2_dout, 16'd0);
    endtask

    initial begin
        reset = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 24'd0; p0_ds = 2'b11; p0_din = 16'd0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 24'd0; p1_ds = 2'b11; p1_din = 16'd0;
        p2_req = 1'b0; p2_we = 1'b0; p2_addr = 24'd0; p2_ds = 2'b11; p2_din = 16'd0;
        sd_dout = 16'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Five idle slots: sync 4 high / 4 low, no access
        to_slot_start();
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            check("idle_sync", sd_sync, ((k % 8) < 4) ? 1'b1 : 1'b0);
            check("idle_oe", sd_oe, 1'b0);
            check("idle_we", sd_we, 1'b0);
        end

        // Single p1 read at 0x000123
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 24'h000123; p1_ds = 2'b11;
        sd_dout = 16'hBEEF;
        to_slot_start();
        check_slot("p1rd", 1'b1, 1'b0, 24'h000123, 2'b11, 16'h0000);
        @(negedge clk);
        check("p1rd_ack", {p2_ack, p1_ack, p0_ack}, 3'b010);
        check("p1rd_dout", p1_dout, 16'hBEEF);
        p1_req = 1'b0;
        @(negedge clk);
        check("p1rd_ack_pulse", p1_ack, 1'b0);
        check("p1rd_dout_hold", p1_dout, 16'hBEEF);

        // p0 write 0x1234 with lower strobe only
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 24'h000456; p0_ds = 2'b01; p0_din = 16'h1234;
        to_slot_start();
        check_slot("p0wr", 1'b0, 1'b1, 24'h000456, 2'b01, 16'h1234);
        @(negedge clk);
        check("p0wr_ack", {p2_ack, p1_ack, p0_ack}, 3'b001);
        check("p0wr_dout", p0_dout, 16'h0000);
        check("p0wr_p1dout", p1_dout, 16'hBEEF);
        p0_req = 1'b0;

        // p2 fully masked write still serviced and acked
        p2_req = 1'b1; p2_we = 1'b1; p2_addr = 24'h0000AA; p2_ds = 2'b00; p2_din = 16'hFFFF;
        to_slot_start();
        check_slot("p2mask", 1'b0, 1'b1, 24'h0000AA, 2'b00, 16'hFFFF);
        @(negedge clk);
        check("p2mask_ack", {p2_ack, p1_ack, p0_ack}, 3'b100);
        check("p2mask_dout", p2_dout, 16'h0000);
        p2_req = 1'b0;

        // p0 and p2 request together: p0, p2, p0 (still requesting)
        sd_dout = 16'hA5A5;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 24'h000010; p0_ds = 2'b11; p0_din = 16'h0000;
        p2_req = 1'b1; p2_we = 1'b0; p2_addr = 24'h000020; p2_ds = 2'b11; p2_din = 16'h0000;
        to_slot_start();
        check_slot("prioS0", 1'b1, 1'b0, 24'h000010, 2'b11, 16'h0000);
        @(negedge clk);
        check("prioS0_ack", {p2_ack, p1_ack, p0_ack}, 3'b001);
        check("prioS0_dout", p0_dout, 16'hA5A5);
        check_slot("prioS1", 1'b1, 1'b0, 24'h000020, 2'b11, 16'h0000);
        @(negedge clk);
        check("prioS1_ack", {p2_ack, p1_ack, p0_ack}, 3'b100);
        check("prioS1_dout", p2_dout, 16'hA5A5);
        p2_req = 1'b0;
        check_slot("prioS2", 1'b1, 1'b0, 24'h000010, 2'b11, 16'h0000);
        @(negedge clk);
        check("prioS2_ack", {p2_ack, p1_ack, p0_ack}, 3'b001);
        check("prioS3_oe", sd_oe, 1'b0);
        check("prioS3_we", sd_we, 1'b0);

        // p0 and p1 continuous: 16 granted slots then one refresh slot
        p0_addr = 24'h000100;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 24'h000200; p1_ds = 2'b11;
        for (int k = 0; k < 34; k++) begin
            int j;
            to_slot_start();
            j = k % 17;
            if (j == 16) begin
                check("refr_idle_oe", sd_oe, 1'b0);
                check("refr_idle_we", sd_we, 1'b0);
            end else begin
                check("refr_busy_oe", sd_oe, 1'b1);
                check("refr_busy_addr", sd_addr, (j % 2 == 0) ? 24'h000100 : 24'h000200);
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        to_slot_start();
        to_slot_start();

        // Reset at cnt 3 of a p2 read
        p2_req = 1'b1; p2_we = 1'b0; p2_addr = 24'h000300; p2_ds = 2'b11;
        to_slot_start();
        check("rstmid_oe", sd_oe, 1'b1);
        check("rstmid_addr", sd_addr, 24'h000300);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("rstmid");
        reset = 1'b0;
        p2_req = 1'b0;
        for (int m = 0; m < 16; m++) begin
            @(negedge clk);
            check("rstmid_noack", p2_ack, 1'b0);
            check("rstmid_sync", sd_sync, (((m + 1) % 8) < 4) ? 1'b1 : 1'b0);
            check("rstmid_oe_after", sd_oe, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
